// File: rtl/xbar_sel_reg_if.sv
// Bus between the port allocator (master) and the crossbar select
// generator (slave): allocation requests in, registered select buses out.
interface xbar_sel_reg_if #(
  parameter int NUM_CHANNEL  = 5,
  parameter int LOG_NUM_PORT = 3,
  parameter int CNT_W        = 8
);

  logic                                alloc_valid;
  logic [NUM_CHANNEL*NUM_CHANNEL-1:0]  alloc_vector;
  logic [NUM_CHANNEL-1:0]              lock_vector;
  logic [NUM_CHANNEL-1:0]              release_vector;

  logic [NUM_CHANNEL*LOG_NUM_PORT-1:0] out_sel_vector;
  logic [NUM_CHANNEL*LOG_NUM_PORT-1:0] in_sel_vector;
  logic [NUM_CHANNEL-1:0]              in_valid;
  logic                                sel_valid;
  logic [NUM_CHANNEL-1:0]              locked;
  logic                                conflict;
  logic [CNT_W-1:0]                    conflict_cnt;

  modport master (
    output alloc_valid, alloc_vector, lock_vector, release_vector,
    input  out_sel_vector, in_sel_vector, in_valid, sel_valid,
           locked, conflict, conflict_cnt
  );

  modport slave (
    input  alloc_valid, alloc_vector, lock_vector, release_vector,
    output out_sel_vector, in_sel_vector, in_valid, sel_valid,
           locked, conflict, conflict_cnt
  );

endinterface

// File: rtl/xbar_sel_reg.sv
// Registered crossbar select generator. Turns per-input one-hot allocation
// rows into an output-per-input select bus and its inverse (input-per-output),
// with NULL encoding for idle fields, lowest-index arbitration, conflict
// detection with a saturating counter, and per-input path locking.
// LOG_NUM_PORT must be wide enough that the value NUM_CHANNEL (the NULL code)
// is representable and distinct from every real port index.
module xbar_sel_reg #(
  parameter int NUM_CHANNEL  = 5,
  parameter int LOG_NUM_PORT = 3,
  parameter int CNT_W        = 8
) (
  input  logic          clk,
  input  logic          reset,
  xbar_sel_reg_if.slave bus
);

  typedef logic [NUM_CHANNEL-1:0]  row_t;
  typedef logic [LOG_NUM_PORT-1:0] sel_t;

  localparam sel_t             NULL_SEL = sel_t'(NUM_CHANNEL);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Index of the lowest set bit; NULL when the row is empty.
  function automatic sel_t lowest_idx(input row_t row);
    sel_t idx;
    idx = NULL_SEL;
    for (int b = NUM_CHANNEL - 1; b >= 0; b--) begin
      idx = row[b] ? sel_t'(b) : idx;
    end
    return idx;
  endfunction

  // True when more than one bit of the row is set (malformed request).
  function automatic logic multi_hot(input row_t row);
    return (row & (row - row_t'(1'b1))) != row_t'(1'b0);
  endfunction

  // Stored path per locked input and the lock flags themselves.
  sel_t [NUM_CHANNEL-1:0] lock_out_q, lock_out_d;
  row_t                   locked_q, locked_d;

  // Registered outputs and their next-state values.
  sel_t [NUM_CHANNEL-1:0] out_sel_q, out_sel_d;
  sel_t [NUM_CHANNEL-1:0] in_sel_q, in_sel_d;
  row_t                   in_valid_q, in_valid_d;
  logic                   sel_valid_q, sel_valid_d;
  logic                   conflict_q, conflict_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Arbitration scratch.
  row_t reserved_s, taken_s, row_s, low_oh_s;

  // Decode rows and arbitrate: locked paths keep their output, lower unlocked
  // inputs win free outputs, everything else is NULL and flags a conflict.
  always_comb begin
    reserved_s = '0;
    taken_s    = '0;
    row_s      = '0;
    low_oh_s   = '0;
    conflict_d = 1'b0;
    for (int j = 0; j < NUM_CHANNEL; j++) begin
      out_sel_d[j] = NULL_SEL;
    end
    for (int j = 0; j < NUM_CHANNEL; j++) begin
      for (int k = 0; k < NUM_CHANNEL; k++) begin
        reserved_s[k] = reserved_s[k] | (locked_q[j] & (lock_out_q[j] == sel_t'(k)));
      end
    end
    for (int j = 0; j < NUM_CHANNEL; j++) begin
      row_s    = bus.alloc_valid ? bus.alloc_vector[j*NUM_CHANNEL +: NUM_CHANNEL] : row_t'(1'b0);
      low_oh_s = row_s & (~row_s + row_t'(1'b1));
      if (locked_q[j]) begin
        out_sel_d[j] = lock_out_q[j];
      end else if (row_s == row_t'(1'b0)) begin
        out_sel_d[j] = NULL_SEL;
      end else begin
        conflict_d = conflict_d | multi_hot(row_s);
        if ((low_oh_s & (reserved_s | taken_s)) != row_t'(1'b0)) begin
          conflict_d   = 1'b1;
          out_sel_d[j] = NULL_SEL;
        end else begin
          taken_s      = taken_s | low_oh_s;
          out_sel_d[j] = lowest_idx(row_s);
        end
      end
    end
  end

  // Build the input-per-output view as the exact inverse of out_sel_d.
  always_comb begin
    in_valid_d = '0;
    for (int k = 0; k < NUM_CHANNEL; k++) begin
      in_sel_d[k] = NULL_SEL;
    end
    for (int k = 0; k < NUM_CHANNEL; k++) begin
      for (int j = 0; j < NUM_CHANNEL; j++) begin
        in_sel_d[k]   = (out_sel_d[j] == sel_t'(k)) ? sel_t'(j) : in_sel_d[k];
        in_valid_d[k] = in_valid_d[k] | (out_sel_d[j] == sel_t'(k));
      end
    end
    sel_valid_d = |in_valid_d;
  end

  // Lock bookkeeping (release beats lock) and saturating conflict counter.
  always_comb begin
    locked_d   = locked_q;
    lock_out_d = lock_out_q;
    for (int j = 0; j < NUM_CHANNEL; j++) begin
      if (locked_q[j]) begin
        if (bus.release_vector[j]) begin
          locked_d[j] = 1'b0;
        end else begin
          locked_d[j] = 1'b1;
        end
      end else if (bus.lock_vector[j] && (out_sel_d[j] != NULL_SEL)) begin
        locked_d[j]   = 1'b1;
        lock_out_d[j] = out_sel_d[j];
      end else begin
        locked_d[j] = 1'b0;
      end
    end
    if (conflict_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline register for all outputs and lock state; reset drops every lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_CHANNEL; j++) begin
        out_sel_q[j]  <= NULL_SEL;
        in_sel_q[j]   <= NULL_SEL;
        lock_out_q[j] <= NULL_SEL;
      end
      in_valid_q  <= '0;
      locked_q    <= '0;
      sel_valid_q <= 1'b0;
      conflict_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_sel_q   <= out_sel_d;
      in_sel_q    <= in_sel_d;
      lock_out_q  <= lock_out_d;
      in_valid_q  <= in_valid_d;
      locked_q    <= locked_d;
      sel_valid_q <= sel_valid_d;
      conflict_q  <= conflict_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_sel_vector = out_sel_q;
  assign bus.in_sel_vector  = in_sel_q;
  assign bus.in_valid       = in_valid_q;
  assign bus.sel_valid      = sel_valid_q;
  assign bus.locked         = locked_q;
  assign bus.conflict       = conflict_q;
  assign bus.conflict_cnt   = cnt_q;

endmodule
